// File: rtl/lcd_power_sequencer.sv
// Purpose: sequences LCD bring-up (timing gen -> DISP -> backlight) and the reverse tear-down, with a vsync watchdog.
// Latency: all outputs registered; step delays are T_PWR_CYC clocks or N_FRAMES_* vsync rising edges.
// Backpressure: none; pwr_req is a level and is ignored until an in-progress power-down completes.
// Optional: define LCD_PWR_FRAME_CNT_EN to add a 16-bit saturating frame counter that runs while ON.
module lcd_power_sequencer #(
    parameter int T_PWR_CYC     = 1000,
    parameter int N_FRAMES_DISP = 2,
    parameter int N_FRAMES_BL   = 4,
    parameter int VS_TIMEOUT    = 200000,
    parameter int CNT_W         = 20
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        pwr_req,
    input  logic        vs,
    output logic        tg_en,
    output logic        lcd_disp,
    output logic        bl_en,
    output logic        busy,
    output logic        fault,
    output logic [3:0]  state
`ifdef LCD_PWR_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int FRM_MAX = (N_FRAMES_DISP > N_FRAMES_BL) ? N_FRAMES_DISP : N_FRAMES_BL;
    localparam int FRM_W   = $clog2(FRM_MAX + 1);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_PWR_WAIT  = 4'd1,
        S_TG_WAIT   = 4'd2,
        S_DISP_WAIT = 4'd3,
        S_ON        = 4'd4,
        S_BL_OFF    = 4'd5,
        S_DISP_OFF  = 4'd6,
        S_TG_OFF    = 4'd7,
        S_FAULT     = 4'd8
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [FRM_W-1:0]   frm_cnt_q, frm_cnt_d;
    logic               vs_q;
    logic               tg_en_q, lcd_disp_q, bl_en_q, busy_q, fault_q;
    logic               vs_rise;
    logic               frame_state;
    logic               wd_expired;
    logic               cyc_done;
    logic               disp_frames_done;
    logic               bl_frames_done;
`ifdef LCD_PWR_FRAME_CNT_EN
    logic [15:0]        frame_cnt_q, frame_cnt_d;
`endif

    assign vs_rise          = vs & ~vs_q;
    assign frame_state      = (state_q == S_TG_WAIT) || (state_q == S_DISP_WAIT) ||
                              (state_q == S_BL_OFF)  || (state_q == S_DISP_OFF);
    assign wd_expired       = frame_state && (cyc_cnt_q == CNT_W'(VS_TIMEOUT - 1));
    assign cyc_done         = (cyc_cnt_q == CNT_W'(T_PWR_CYC - 1));
    assign disp_frames_done = vs_rise && (frm_cnt_q == FRM_W'(N_FRAMES_DISP - 1));
    assign bl_frames_done   = vs_rise && (frm_cnt_q == FRM_W'(N_FRAMES_BL - 1));

    // Next state and counters; watchdog expiry outranks pwr_req and frame ticks.
    always_comb begin
        state_d   = state_q;
        cyc_cnt_d = cyc_cnt_q;
        frm_cnt_d = frm_cnt_q;
        case (state_q)
            S_OFF:       if (pwr_req) state_d = S_PWR_WAIT;
            S_PWR_WAIT:  if (!pwr_req) state_d = S_OFF;
                         else if (cyc_done) state_d = S_TG_WAIT;
            S_TG_WAIT:   if (wd_expired) state_d = S_FAULT;
                         else if (!pwr_req) state_d = S_DISP_OFF;
                         else if (disp_frames_done) state_d = S_DISP_WAIT;
            S_DISP_WAIT: if (wd_expired) state_d = S_FAULT;
                         else if (!pwr_req) state_d = S_BL_OFF;
                         else if (bl_frames_done) state_d = S_ON;
            S_ON:        if (!pwr_req) state_d = S_BL_OFF;
            S_BL_OFF:    if (wd_expired) state_d = S_FAULT;
                         else if (bl_frames_done) state_d = S_DISP_OFF;
            S_DISP_OFF:  if (wd_expired) state_d = S_FAULT;
                         else if (disp_frames_done) state_d = S_TG_OFF;
            S_TG_OFF:    if (cyc_done) state_d = S_OFF;
            S_FAULT:     if (!pwr_req) state_d = S_OFF;
            default:     state_d = S_OFF;
        endcase

        // A tick landing on the entry edge is swallowed by the entry clear.
        if (state_d != state_q) begin
            cyc_cnt_d = '0;
            frm_cnt_d = '0;
        end else if (vs_rise) begin
            cyc_cnt_d = '0;
            if (frame_state) frm_cnt_d = frm_cnt_q + 1'b1;
        end else if (frame_state || (state_q == S_PWR_WAIT) || (state_q == S_TG_OFF)) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

`ifdef LCD_PWR_FRAME_CNT_EN
    // Frames seen while ON, restarted on every ON entry and held at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d == S_ON && state_q != S_ON)
            frame_cnt_d = '0;
        else if (state_q == S_ON && vs_rise && frame_cnt_q != 16'hFFFF)
            frame_cnt_d = frame_cnt_q + 16'd1;
    end
`endif

    // State, counters and outputs decoded from the next state so enables move on the transition edge.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            cyc_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            vs_q       <= 1'b1;
            tg_en_q    <= 1'b0;
            lcd_disp_q <= 1'b0;
            bl_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
`ifdef LCD_PWR_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            vs_q       <= vs;
            tg_en_q    <= state_d inside {S_TG_WAIT, S_DISP_WAIT, S_ON, S_BL_OFF, S_DISP_OFF};
            lcd_disp_q <= state_d inside {S_DISP_WAIT, S_ON, S_BL_OFF};
            bl_en_q    <= (state_d == S_ON);
            busy_q     <= !(state_d inside {S_OFF, S_ON, S_FAULT});
            fault_q    <= (state_d == S_FAULT);
`ifdef LCD_PWR_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign tg_en    = tg_en_q;
    assign lcd_disp = lcd_disp_q;
    assign bl_en    = bl_en_q;
    assign busy     = busy_q;
    assign fault    = fault_q;
    assign state    = state_q;
`ifdef LCD_PWR_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Bench for lcd_power_sequencer: a vsync source gated by tg_en plays the timing generator,
// and expectations come from edge/tick counting against the documented sequencing rules.
// Build with LCD_PWR_FRAME_CNT_EN defined to also exercise frame_cnt.
module tb_lcd_power_sequencer;

    localparam int T_PWR = 8;
    localparam int ND    = 2;
    localparam int NB    = 3;
    localparam int VST   = 100;

    // Expected {tg_en, lcd_disp, bl_en, busy, fault, state[3:0]} per phase of the sequence.
    localparam logic [8:0] E_OFF     = 9'b0_0_0_0_0_0000;
    localparam logic [8:0] E_PWR     = 9'b0_0_0_1_0_0001;
    localparam logic [8:0] E_TG      = 9'b1_0_0_1_0_0010;
    localparam logic [8:0] E_DISP    = 9'b1_1_0_1_0_0011;
    localparam logic [8:0] E_ON      = 9'b1_1_1_0_0_0100;
    localparam logic [8:0] E_BLOFF   = 9'b1_1_0_1_0_0101;
    localparam logic [8:0] E_DISPOFF = 9'b1_0_0_1_0_0110;
    localparam logic [8:0] E_TGOFF   = 9'b0_0_0_1_0_0111;
    localparam logic [8:0] E_FAULT   = 9'b0_0_0_0_1_1000;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        pwr_req;
    logic        vs;
    logic        tg_en, lcd_disp, bl_en, busy, fault;
    logic [3:0]  state;
    logic [8:0]  obs;
`ifdef LCD_PWR_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int  total = 0;
    int  bad   = 0;
    int  vs_per = 40;
    int  vs_low = 4;
    bit  vs_stall = 1'b0;
    int  tick_cnt = 0;
    logic vs_prev = 1'b1;

    assign obs = {tg_en, lcd_disp, bl_en, busy, fault, state};

    always #5 vga_clk = ~vga_clk;

    lcd_power_sequencer #(
        .T_PWR_CYC    (T_PWR),
        .N_FRAMES_DISP(ND),
        .N_FRAMES_BL  (NB),
        .VS_TIMEOUT   (VST),
        .CNT_W        (20)
    ) dut (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .pwr_req  (pwr_req),
        .vs       (vs),
        .tg_en    (tg_en),
        .lcd_disp (lcd_disp),
        .bl_en    (bl_en),
        .busy     (busy),
        .fault    (fault),
        .state    (state)
`ifdef LCD_PWR_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    // Frame ticks as the bench drove them: vs high at an edge after being low at the previous edge.
    always @(posedge vga_clk) begin
        if (vs && !vs_prev) tick_cnt <= tick_cnt + 1;
        vs_prev <= vs;
    end

    // Timing generator stand-in: free-running vsync only while tg_en is high and not stalled.
    initial begin
        int ph;
        ph = 0;
        vs = 1'b1;
        forever begin
            @(negedge vga_clk);
            if (!tg_en || vs_stall) begin
                ph = 0;
                vs = 1'b1;
            end else begin
                ph = (ph + 1) % vs_per;
                vs = (ph >= vs_per - vs_low) ? 1'b0 : 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    // Advance until n more frame ticks have been seen; ok=0 if the cycle budget runs out.
    task automatic wait_ticks(input int n, output bit ok);
        int start;
        int budget;
        start  = tick_cnt;
        budget = n * (vs_per + 4) + 8;
        ok     = 1'b1;
        while (tick_cnt < start + n) begin
            if (budget == 0) begin
                ok = 1'b0;
                break;
            end
            budget--;
            @(negedge vga_clk);
        end
    endtask

    // Power-up from OFF; stop_at 2 = stop in TG_WAIT, 1 = stop in DISP_WAIT, 0 = run to ON.
    task automatic power_up(input string tag, input int stop_at);
        bit ok;
        pwr_req = 1'b1;
        repeat (T_PWR) @(negedge vga_clk);
        total++;
        if (obs !== E_PWR) begin bad++; $display("FAIL %s pre_tg obs=%b exp=%b", tag, obs, E_PWR); end
        @(negedge vga_clk);
        total++;
        if (obs !== E_TG) begin bad++; $display("FAIL %s tg_rise obs=%b exp=%b", tag, obs, E_TG); end
        if (stop_at == 2) return;
        wait_ticks(ND - 1, ok);
        total++;
        if (!ok || obs !== E_TG) begin bad++; $display("FAIL %s pre_disp obs=%b exp=%b timeout=%0d", tag, obs, E_TG, !ok); end
        wait_ticks(1, ok);
        total++;
        if (!ok || obs !== E_DISP) begin bad++; $display("FAIL %s disp_rise obs=%b exp=%b timeout=%0d", tag, obs, E_DISP, !ok); end
        if (stop_at == 1) return;
        wait_ticks(NB - 1, ok);
        total++;
        if (!ok || obs !== E_DISP) begin bad++; $display("FAIL %s pre_bl obs=%b exp=%b timeout=%0d", tag, obs, E_DISP, !ok); end
        wait_ticks(1, ok);
        total++;
        if (!ok || obs !== E_ON) begin bad++; $display("FAIL %s bl_rise obs=%b exp=%b timeout=%0d", tag, obs, E_ON, !ok); end
    endtask

    // Drop pwr_req from DISP_WAIT or ON and follow the tear-down to OFF.
    task automatic power_down(input string tag);
        bit ok;
        pwr_req = 1'b0;
        @(negedge vga_clk);
        total++;
        if (obs !== E_BLOFF) begin bad++; $display("FAIL %s bl_fall obs=%b exp=%b", tag, obs, E_BLOFF); end
        wait_ticks(NB - 1, ok);
        total++;
        if (!ok || obs !== E_BLOFF) begin bad++; $display("FAIL %s pre_disp_fall obs=%b exp=%b timeout=%0d", tag, obs, E_BLOFF, !ok); end
        wait_ticks(1, ok);
        total++;
        if (!ok || obs !== E_DISPOFF) begin bad++; $display("FAIL %s disp_fall obs=%b exp=%b timeout=%0d", tag, obs, E_DISPOFF, !ok); end
        wait_ticks(ND - 1, ok);
        total++;
        if (!ok || obs !== E_DISPOFF) begin bad++; $display("FAIL %s pre_tg_fall obs=%b exp=%b timeout=%0d", tag, obs, E_DISPOFF, !ok); end
        wait_ticks(1, ok);
        total++;
        if (!ok || obs !== E_TGOFF) begin bad++; $display("FAIL %s tg_fall obs=%b exp=%b timeout=%0d", tag, obs, E_TGOFF, !ok); end
        repeat (T_PWR - 1) @(negedge vga_clk);
        total++;
        if (obs !== E_TGOFF) begin bad++; $display("FAIL %s pre_off obs=%b exp=%b", tag, obs, E_TGOFF); end
        @(negedge vga_clk);
        total++;
        if (obs !== E_OFF) begin bad++; $display("FAIL %s off obs=%b exp=%b", tag, obs, E_OFF); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwr_req = 1'b1;
        repeat (3) @(negedge vga_clk);
        total++;
        if (obs !== E_OFF) begin bad++; $display("FAIL reset obs=%b exp=%b", obs, E_OFF); end
        pwr_req = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge vga_clk);
        total++;
        if (obs !== E_OFF) begin bad++; $display("FAIL idle_after_reset obs=%b exp=%b", obs, E_OFF); end
    endtask

    task automatic test_power_up_down();
        power_up("up", 0);
        repeat (10) @(negedge vga_clk);
        total++;
        if (obs !== E_ON) begin bad++; $display("FAIL on_hold obs=%b exp=%b", obs, E_ON); end
        power_down("down");
    endtask

    task automatic test_abort();
        bit ok;
        bit tg_seen;
        power_up("abort_disp", 1);
        wait_ticks(1, ok);
        total++;
        if (!ok || obs !== E_DISP) begin bad++; $display("FAIL abort_disp_1frame obs=%b exp=%b timeout=%0d", obs, E_DISP, !ok); end
        power_down("abort_disp");
        pwr_req = 1'b1;
        tg_seen = 1'b0;
        repeat (4) @(negedge vga_clk);
        total++;
        if (obs !== E_PWR) begin bad++; $display("FAIL abort_pwr_wait obs=%b exp=%b", obs, E_PWR); end
        pwr_req = 1'b0;
        @(negedge vga_clk);
        total++;
        if (obs !== E_OFF) begin bad++; $display("FAIL abort_pwr_off obs=%b exp=%b", obs, E_OFF); end
        repeat (20) begin
            @(negedge vga_clk);
            if (tg_en) tg_seen = 1'b1;
        end
        total++;
        if (tg_seen) begin bad++; $display("FAIL abort_pwr_tg got=1 exp=0"); end
    endtask

    task automatic test_watchdog();
        vs_stall = 1'b1;
        power_up("wd", 2);
        repeat (VST - 1) @(negedge vga_clk);
        total++;
        if (obs !== E_TG) begin bad++; $display("FAIL wd_pre obs=%b exp=%b", obs, E_TG); end
        @(negedge vga_clk);
        total++;
        if (obs !== E_FAULT) begin bad++; $display("FAIL wd_fault obs=%b exp=%b", obs, E_FAULT); end
        repeat ($urandom_range(5, 30)) @(negedge vga_clk);
        total++;
        if (obs !== E_FAULT) begin bad++; $display("FAIL wd_hold obs=%b exp=%b", obs, E_FAULT); end
        vs_stall = 1'b0;
        pwr_req = 1'b0;
        @(negedge vga_clk);
        total++;
        if (obs !== E_OFF) begin bad++; $display("FAIL wd_exit obs=%b exp=%b", obs, E_OFF); end
    endtask

    task automatic test_reset_mid();
        power_up("rst_mid", 1);
        rst = 1'b1;
        @(negedge vga_clk);
        total++;
        if (obs !== E_OFF) begin bad++; $display("FAIL rst_mid obs=%b exp=%b", obs, E_OFF); end
        rst = 1'b0;
        power_up("rst_restart", 0);
        power_down("rst_restart");
    endtask

    task automatic test_random_cycles();
        for (int i = 0; i < 3; i++) begin
            vs_per = $urandom_range(20, 60);
            vs_low = $urandom_range(1, 6);
            power_up("rand", 0);
            repeat ($urandom_range(0, 50)) @(negedge vga_clk);
            power_down("rand");
            repeat ($urandom_range(1, 10)) @(negedge vga_clk);
        end
        vs_per = 40;
        vs_low = 4;
    endtask

`ifdef LCD_PWR_FRAME_CNT_EN
    task automatic test_frame_cnt();
        bit ok;
        power_up("fcnt", 0);
        wait_ticks(5, ok);
        total++;
        if (!ok || frame_cnt !== 16'd5) begin bad++; $display("FAIL fcnt_five got=%0d exp=5 timeout=%0d", frame_cnt, !ok); end
        power_down("fcnt");
        power_up("fcnt_again", 0);
        total++;
        if (frame_cnt !== 16'd0) begin bad++; $display("FAIL fcnt_restart got=%0d exp=0", frame_cnt); end
        power_down("fcnt_again");
    endtask
`endif

    initial begin
        rst = 1'b1;
        pwr_req = 1'b0;
        test_reset();
        test_power_up_down();
        test_abort();
        test_watchdog();
        test_reset_mid();
        test_random_cycles();
`ifdef LCD_PWR_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
